// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first successive-approximation search driven through a one-hot magnitude comparator.
// Optional feature: define SAR_EARLY_EXIT_EN to end a search as soon as the comparator reports equality.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    localparam int IW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DECIDE, S_DONE} state_t;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_guess, w_guess_nxt, r_result, w_result_nxt, w_bit, w_work;
    logic [IW-1:0]    r_idx, w_idx_nxt;
    logic             r_err, w_err_nxt, w_onehot, w_early;
`ifdef SAR_EARLY_EXIT_EN
    assign w_early = cmp_eq;
`else
    assign w_early = 1'b0;
`endif
    assign w_onehot = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                      ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                      ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);
    assign w_bit    = WIDTH'(1) << r_idx;
    assign w_work   = cmp_lt ? (r_guess & ~w_bit) : r_guess;
    assign guess    = r_guess;
    assign result   = r_result;
    assign err      = r_err;
    assign busy     = (r_state == S_SETTLE) || (r_state == S_DECIDE);
    assign done     = (r_state == S_DONE);
    // State and search registers; guess doubles as the working value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_guess  <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_guess  <= w_guess_nxt;
            r_result <= w_result_nxt;
            r_idx    <= w_idx_nxt;
            r_err    <= w_err_nxt;
        end
    end
    // Next-state and datapath decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_guess_nxt  = r_guess;
        w_result_nxt = r_result;
        w_idx_nxt    = r_idx;
        w_err_nxt    = r_err;
        case (r_state)
            S_IDLE: if (start) begin
                w_state_nxt  = S_SETTLE;
                w_result_nxt = '0;
                w_err_nxt    = 1'b0;
                w_guess_nxt  = WIDTH'(1) << (WIDTH - 1);
                w_idx_nxt    = IW'(WIDTH - 1);
            end
            S_SETTLE: w_state_nxt = S_DECIDE;
            S_DECIDE: if (!w_onehot) begin
                w_state_nxt  = S_DONE;
                w_err_nxt    = 1'b1;
                w_result_nxt = r_guess;
            end else if (r_idx == '0 || w_early) begin
                w_state_nxt  = S_DONE;
                w_result_nxt = w_work;
            end else begin
                w_state_nxt  = S_SETTLE;
                w_idx_nxt    = r_idx - IW'(1);
                w_guess_nxt  = w_work | (WIDTH'(1) << (r_idx - IW'(1)));
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Successive-approximation search controller: the initiator side of the team's magnitude comparator. It drives a trial value onto the comparator's B input and reads back the one-hot greater/equal/less flags. It then binary-searches, MSB first, to recover the unknown value on the comparator's A input. It is used wherever a value is only observable through a compare, such as threshold trimming or ADC-style measurement loops.

## Interface
Parameters:
- WIDTH, 4, width of the searched value and the comparator operands; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a search; honoured only in IDLE.
- guess  output  WIDTH  trial value; drives comparator operand B.
- cmp_gt  input  1  comparator "A greater than B" flag.
- cmp_eq  input  1  comparator "A equal to B" flag.
- cmp_lt  input  1  comparator "A less than B" flag.
- busy  output  1  high in SETTLE and DECIDE.
- done  output  1  one-cycle pulse on completion or abort.
- result  output  WIDTH  recovered value; held until the next accepted start.
- err  output  1  set on an illegal flag combination; held until the next accepted start.

## Operation
The controller has four states: IDLE, SETTLE, DECIDE and DONE. It keeps an internal bit index `idx` that runs from WIDTH-1 down to 0.

- **IDLE**
  - On `start=1`: clear `err` and `result`.
  - Set `guess = 1 << (WIDTH-1)` and `idx = WIDTH-1`.
  - Go to SETTLE.
- **SETTLE**
  - Hold `guess` for one cycle so the comparator settles.
  - Go to DECIDE.
- **DECIDE**: sample `{cmp_gt, cmp_eq, cmp_lt}`.
  - If the flags are not exactly one-hot: set `err=1`, set `result = guess`, go to DONE (abort).
  - If `cmp_lt`: clear bit `idx` of the working value.
  - If `cmp_gt` or `cmp_eq`: keep bit `idx`.
  - If `idx==0`, or the early-exit condition holds (see Configuration): set `result` to the working value and go to DONE.
  - Otherwise: decrement `idx`, set `guess` to the working value OR (1 << new `idx`), and go to SETTLE.
- **DONE**
  - Assert `done` for one cycle.
  - Go to IDLE.
- Ignored inputs:
  - `start` is ignored in SETTLE, DECIDE and DONE; it is not queued.
  - Comparator flags are ignored outside DECIDE.
- Arithmetic: all values are unsigned WIDTH-bit; no carries and no wrap-around are possible.

## Timing
- **Reset**
  - `rst_n=0` forces IDLE immediately, asynchronously, from any state.
  - Output values under reset: `guess=0`, `busy=0`, `done=0`, `result=0`, `err=0`.
  - A reset mid-search discards all progress; no `done` pulse is issued.
- **Cycle counting**: edge 0 is the clock edge that samples `start` in IDLE.
  - One trial takes 2 cycles (SETTLE, then DECIDE).
  - `busy` rises after edge 0 and falls at the edge that enters DONE.
- **Full search**: DONE is entered at edge 2·WIDTH, and `done` is high for the following cycle.
- **Ready for a new start**: IDLE is re-entered one edge after DONE is entered. A `start` held high continuously therefore begins a new search 2·WIDTH+2 edges after the previous one.
- **Output stability**
  - `guess` changes only at edges that enter SETTLE; it is stable throughout DECIDE.
  - `result` and `err` update only at the edge that enters DONE (or when a start is accepted) and are stable while `done` is high.

## Configuration
- Macro: `SAR_EARLY_EXIT_EN`.
- **Defined**: `cmp_eq=1` in DECIDE ends the search immediately with `result = guess`.
  - Latency becomes 2·(number of trials actually run).
  - The minimum latency is 2 edges, reached when A equals the MSB-only value.
- **Undefined**: `cmp_eq` is treated exactly like `cmp_gt` (keep the bit). Every search runs all WIDTH trials, giving a fixed latency of 2·WIDTH.

## Test plan
All scenarios use WIDTH=4 with an ideal comparator model connected to A and `guess`.

- **A=9**: guesses 1000, 1100, 1010, 1001 → `result=1001`, `err=0`, `done` at edge 8 (both configurations).
- **A=8, `SAR_EARLY_EXIT_EN` defined**: a single guess of 1000 → `result=1000`, `done` at edge 2.
- **A=8, `SAR_EARLY_EXIT_EN` undefined**: guesses 1000, 1100, 1010, 1001 → `result=1000`, `done` at edge 8.
- **Range extremes**
  - A=0 → guesses 1000, 0100, 0010, 0001 → `result=0000`.
  - A=15 → guesses 1000, 1100, 1110, 1111 → `result=1111`.
- **Fault injection**: force `{gt,eq,lt}=3'b110` in the second DECIDE → `err=1`, `result=1100`, `done` at edge 4. The next start clears `err`.
- **Control corner cases**
  - Pulse `start` while `busy=1` → ignored; `result` is unchanged.
  - Assert `rst_n=0` in the third SETTLE → all outputs 0 immediately, no `done` pulse.
  - A subsequent search after reset completes normally.
